// File: rtl/ex_stage.sv
// Execute stage of the SimpleRisc pipeline: single-cycle ALU, flags, branch resolution,
// and an iterative signed restoring divider that stalls upstream while busy.
module ex_stage #(
    parameter int unsigned DW         = 32,
    parameter int unsigned DIV_CYCLES = 32
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] Instruction,
    input  logic [DW-1:0] PC_Current,
    input  logic [DW-1:0] op1,
    input  logic [DW-1:0] op2,
    input  logic [DW-1:0] Immd,
    input  logic [DW-1:0] Branch_Target,
    input  logic [4:0]    AluSignal,
    input  logic          IsSt,
    input  logic          IsLd,
    input  logic          IsBeq,
    input  logic          IsBgt,
    input  logic          IsRet,
    input  logic          IsImmediate,
    input  logic          IsWb,
    input  logic          IsUBranch,
    input  logic          IsCall,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_Instruction,
    output logic [DW-1:0] out_PC_Current,
    output logic [DW-1:0] out_AluResult,
    output logic [DW-1:0] out_op2,
    output logic          out_IsSt,
    output logic          out_IsLd,
    output logic          out_IsWb,
    output logic          out_IsCall,
    output logic          branch_taken,
    output logic [DW-1:0] branch_pc,
    output logic          flag_E,
    output logic          flag_GT
);

    localparam int unsigned SHW = $clog2(DW);
    localparam int unsigned CW  = $clog2(DIV_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DIV_BUSY, DIV_DONE} state_t;

    typedef enum logic [4:0] {
        ALU_ADD = 5'd0,  ALU_SUB = 5'd1,  ALU_MUL = 5'd2,  ALU_DIV = 5'd3,
        ALU_MOD = 5'd4,  ALU_CMP = 5'd5,  ALU_AND = 5'd6,  ALU_OR  = 5'd7,
        ALU_NOT = 5'd8,  ALU_MOV = 5'd9,  ALU_LSL = 5'd10, ALU_LSR = 5'd11,
        ALU_ASR = 5'd12
    } alu_op_t;

    state_t state;

    logic [DW-1:0] b_val, alu_res, abs_a, abs_b;
    logic          accept, is_div_op, take, out_free;

    // Divider working state plus the instruction fields held while it runs
    logic [DW-1:0] div_q, div_r, div_d;
    logic [CW-1:0] div_cnt;
    logic          div_sa, div_sb, div_mod, div_zero;
    logic [DW-1:0] hold_instr, hold_pc, hold_op2;
    logic          hold_st, hold_ld, hold_wb, hold_call;

    logic [DW:0]   r_shift, diff;
    logic [DW-1:0] q_fin, r_fin, div_res;

    assign out_free  = !out_valid || out_ready;
    assign in_ready  = (state == IDLE) && out_free;
    assign accept    = in_valid && in_ready;
    assign is_div_op = (AluSignal == ALU_DIV) || (AluSignal == ALU_MOD);
    assign take      = !is_div_op && (IsUBranch || (IsBeq && flag_E) || (IsBgt && flag_GT));

    always_comb begin
        b_val   = IsImmediate ? Immd : op2;
        abs_a   = op1[DW-1] ? -op1 : op1;
        abs_b   = b_val[DW-1] ? -b_val : b_val;
        alu_res = '0;
        case (AluSignal)
            ALU_ADD: alu_res = op1 + b_val;
            ALU_SUB: alu_res = op1 - b_val;
            ALU_MUL: alu_res = op1 * b_val;
            ALU_AND: alu_res = op1 & b_val;
            ALU_OR:  alu_res = op1 | b_val;
            ALU_NOT: alu_res = ~b_val;
            ALU_MOV: alu_res = b_val;
            ALU_LSL: alu_res = op1 << b_val[SHW-1:0];
            ALU_LSR: alu_res = op1 >> b_val[SHW-1:0];
            ALU_ASR: alu_res = $unsigned($signed(op1) >>> b_val[SHW-1:0]);
            default: alu_res = '0;
        endcase
    end

    // Restoring step: shift next dividend bit into the partial remainder, subtract if it fits
    always_comb begin
        r_shift = {div_r, div_q[DW-1]};
        diff    = r_shift - {1'b0, div_d};
        q_fin   = div_zero ? '1 : ((div_sa ^ div_sb) ? -div_q : div_q);
        r_fin   = div_sa ? -div_r : div_r;
        div_res = div_mod ? r_fin : q_fin;
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state           <= IDLE;
            out_valid       <= 1'b0;
            out_Instruction <= '0;
            out_PC_Current  <= '0;
            out_AluResult   <= '0;
            out_op2         <= '0;
            out_IsSt        <= 1'b0;
            out_IsLd        <= 1'b0;
            out_IsWb        <= 1'b0;
            out_IsCall      <= 1'b0;
            branch_taken    <= 1'b0;
            branch_pc       <= '0;
            flag_E          <= 1'b0;
            flag_GT         <= 1'b0;
            div_q           <= '0;
            div_r           <= '0;
            div_d           <= '0;
            div_cnt         <= '0;
            div_sa          <= 1'b0;
            div_sb          <= 1'b0;
            div_mod         <= 1'b0;
            div_zero        <= 1'b0;
            hold_instr      <= '0;
            hold_pc         <= '0;
            hold_op2        <= '0;
            hold_st         <= 1'b0;
            hold_ld         <= 1'b0;
            hold_wb         <= 1'b0;
            hold_call       <= 1'b0;
        end else begin
            branch_taken <= 1'b0;
            if (out_valid && out_ready)
                out_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (accept && is_div_op) begin
                        div_d      <= abs_b;
                        div_sa     <= op1[DW-1];
                        div_sb     <= b_val[DW-1];
                        div_mod    <= (AluSignal == ALU_MOD);
                        div_zero   <= (b_val == '0);
                        div_cnt    <= '0;
                        hold_instr <= Instruction;
                        hold_pc    <= PC_Current;
                        hold_op2   <= op2;
                        hold_st    <= IsSt;
                        hold_ld    <= IsLd;
                        hold_wb    <= IsWb;
                        hold_call  <= IsCall;
                        // Divide by zero parks |A| as the remainder so the normal sign fix yields A
                        if (b_val == '0) begin
                            div_q <= '0;
                            div_r <= abs_a;
                            state <= DIV_DONE;
                        end else begin
                            div_q <= abs_a;
                            div_r <= '0;
                            state <= DIV_BUSY;
                        end
                    end else if (accept) begin
                        out_valid       <= 1'b1;
                        out_Instruction <= Instruction;
                        out_PC_Current  <= PC_Current;
                        out_AluResult   <= alu_res;
                        out_op2         <= op2;
                        out_IsSt        <= IsSt;
                        out_IsLd        <= IsLd;
                        out_IsWb        <= IsWb;
                        out_IsCall      <= IsCall;
                        if (AluSignal == ALU_CMP) begin
                            flag_E  <= (op1 == b_val);
                            flag_GT <= ($signed(op1) > $signed(b_val));
                        end
                        if (take) begin
                            branch_taken <= 1'b1;
                            branch_pc    <= IsRet ? op1 : Branch_Target;
                        end
                    end
                end
                DIV_BUSY: begin
                    if (!diff[DW]) begin
                        div_r <= diff[DW-1:0];
                        div_q <= {div_q[DW-2:0], 1'b1};
                    end else begin
                        div_r <= r_shift[DW-1:0];
                        div_q <= {div_q[DW-2:0], 1'b0};
                    end
                    div_cnt <= div_cnt + CW'(1);
                    if (div_cnt == CW'(DIV_CYCLES - 1))
                        state <= DIV_DONE;
                end
                DIV_DONE: begin
                    if (out_free) begin
                        out_valid       <= 1'b1;
                        out_Instruction <= hold_instr;
                        out_PC_Current  <= hold_pc;
                        out_AluResult   <= div_res;
                        out_op2         <= hold_op2;
                        out_IsSt        <= hold_st;
                        out_IsLd        <= hold_ld;
                        out_IsWb        <= hold_wb;
                        out_IsCall      <= hold_call;
                        state           <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
